inst_fetch_unit: RTL and testbench
==================================

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-low (rst=0 sampled at posedge clk resets the block).
REQ-004 SHALL have port: freeze  input  1  hazard stall from the IF/ID consumer; the queue head is not consumed.
REQ-005 SHALL have port: branch_taken  input  1  redirect pulse from EX.
REQ-006 SHALL have port: branch_addr  input  32  redirect target, word aligned.
REQ-007 SHALL have port: imem_req  output  1  instruction memory read request.
REQ-008 SHALL have port: imem_addr  output  32  read address, equals fetch PC while imem_req=1.
REQ-009 SHALL have port: imem_ack  input  1  read data valid; only meaningful while imem_req=1; may be asserted in the same cycle as imem_req.
REQ-010 SHALL have port: imem_rdata  input  32  read data, sampled when imem_req and imem_ack are both 1.
REQ-011 SHALL have port: instruction_IF  output  32  queue-head instruction to the IF/ID register; 0 when fetch_valid=0.
REQ-012 SHALL have port: pc_IF  output  32  queue-head fetch address+4; 0 when fetch_valid=0.
REQ-013 SHALL have port: fetch_valid  output  1  queue non-empty.

Function
REQ-014 SHALL hold a fetch PC register and a prefetch queue of DEPTH entries, each {instr, addr+4}, plus an occupancy counter 0..DEPTH.
REQ-015 SHALL implement FSM states IDLE (imem_req=0), REQ (imem_req=1), DROP (imem_req=1, returned data discarded).
REQ-016 SHALL define consume = fetch_valid & ~freeze & ~branch_taken; consume pops the head at the clock edge.
REQ-017 SHALL, in REQ with imem_ack=1, push {imem_rdata, pc+4} and set pc<=pc+4; next state REQ if next occupancy<DEPTH, else IDLE.
REQ-018 SHALL keep imem_req and imem_addr stable from assertion until imem_ack; a request is never withdrawn.
REQ-019 SHALL move IDLE->REQ when next occupancy<DEPTH; a request is issued only when its queue slot is guaranteed, so overflow is impossible.
REQ-020 SHALL sustain one instruction per cycle with a same-cycle-ack memory and no freeze; the first data appears on the outputs one cycle after its ack.
REQ-021 SHALL, on branch_taken=1, set pc<=branch_addr and clear the queue (occupancy 0) in the same edge; branch_taken wins over freeze and over a simultaneous push.
REQ-022 SHALL, on branch_taken in REQ without imem_ack, go to DROP; in DROP, keep imem_addr at the old address and, on imem_ack, discard the data and go to REQ at the new pc.
REQ-023 SHALL, on branch_taken in REQ with imem_ack in the same cycle, discard the data and go directly to REQ at branch_addr.
REQ-024 SHALL, on branch_taken while in DROP, update pc again and remain in DROP.
REQ-025 SHALL, on simultaneous push and pop, leave occupancy unchanged and preserve order.
REQ-026 SHALL wrap PC arithmetic modulo 2^32 (32'hFFFF_FFFC+4 = 0).

Reset
REQ-027 SHALL, on rst=0 at posedge clk, set pc=RESET_PC, occupancy=0, state=IDLE, and zero all queue entries, overriding every other input.
REQ-028 SHALL, after a reset that interrupts an outstanding request, ignore any later imem_ack until its own next request.
REQ-029 SHALL drive imem_req=0, fetch_valid=0, instruction_IF=0 and pc_IF=0 during and immediately after reset; first request in the cycle after rst returns to 1.

Configuration
REQ-030 SHALL use macro FETCH_PREFETCH_EN: defined -> DEPTH=2 (fetch continues one instruction ahead under freeze); undefined -> DEPTH=1 (single output register, no fetch while it is full and frozen); ports identical in both builds.

Verification
REQ-031 SHALL cover: reset release, RESET_PC=0, same-cycle-ack memory, data I0..I3 -> instruction_IF I0..I3 on consecutive cycles with pc_IF 4,8,12,16.
REQ-032 SHALL cover: freeze=1 for 3 cycles at head I1 -> outputs hold I1/8; DEPTH=2: one more request issued, then imem_req=0; DEPTH=1: imem_req=0 throughout.
REQ-033 SHALL cover: 3-cycle-latency memory, branch_taken to 0x100 one cycle after request at 0x8 -> DROP; data at 0x8 discarded; next imem_addr=0x100; first valid pc_IF=0x104.
REQ-034 SHALL cover: branch_taken and freeze both 1 with queue full -> queue emptied, fetch_valid=0 next cycle, pc=branch_addr.
REQ-035 SHALL cover: rst=0 asserted mid-request at addr 0x20 with ack arriving two cycles later -> ack ignored, outputs 0, fetch restarts at RESET_PC.
REQ-036 SHALL cover: pc at 32'hFFFF_FFFC fetched -> pc_IF=0, next imem_addr=0.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: fetch PC, IDLE/REQ/DROP memory request FSM and a small prefetch queue.
// Build option FETCH_PREFETCH_EN selects a two-entry queue; without it the queue is one entry deep.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_IF,
    output logic [31:0] pc_IF,
    output logic        fetch_valid
);

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int CW = 2;
    localparam int QW = DEPTH * 64;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     drop_addr_q, drop_addr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [QW-1:0]   q_q, q_d;
    logic [CW-1:0]   wr_idx;
    logic            pop;
    logic            push;
    logic            room;
    logic [63:0]     head;

    // Queue entries are {instr, addr+4}; entry 0 (lowest 64 bits) is the head.
    assign head           = q_q[63:0];
    assign fetch_valid    = (count_q != '0);
    assign instruction_IF = fetch_valid ? head[63:32] : 32'h0;
    assign pc_IF          = fetch_valid ? head[31:0]  : 32'h0;

    assign imem_req  = (state_q != IDLE);
    assign imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;

    assign pop    = fetch_valid & ~freeze & ~branch_taken;
    assign push   = (state_q == REQ) & imem_ack & ~branch_taken;
    assign wr_idx = count_q - {1'b0, pop};
    assign room   = (count_d < DEPTH_C);

    always_comb begin
        q_d     = q_q;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        if (pop) begin
            q_d = q_q >> 64;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (wr_idx == i[CW-1:0])) begin
                q_d[i*64 +: 64] = {imem_rdata, pc_q + 32'd4};
            end
        end
        if (branch_taken) begin
            q_d     = '0;
            count_d = '0;
        end
    end

    // A request is only raised once its queue slot is certain, and never withdrawn before its ack.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        unique case (state_q)
            IDLE: begin
                if (room) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (branch_taken) begin
                    if (!imem_ack) begin
                        state_d     = DROP;
                        drop_addr_d = pc_q;
                    end
                end else if (imem_ack) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = room ? REQ : IDLE;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        if (branch_taken) begin
            pc_d = branch_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
            count_q     <= '0;
            q_q         <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            count_q     <= count_d;
            q_q         <= q_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: vector table, directed corner sequences and a random
// run, all compared against a queue-based reference model of the fetch rules.
module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction_IF;
    logic [31:0] pc_IF;
    logic        fetch_valid;

    inst_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_addr    (branch_addr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instruction_IF (instruction_IF),
        .pc_IF          (pc_IF),
        .fetch_valid    (fetch_valid)
    );

    always #5 clk = ~clk;

    int    npass = 0;
    int    ntotal = 0;
    string phase = "init";

    // Reference model: pending-request flag, discard flag, and an ordered queue of fetched words.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcp4;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_drop_addr = 32'h0;
    bit          m_out = 1'b0;
    bit          m_drop = 1'b0;
    int          m_wait = 0;
    int          lat = 0;
    bit          rand_ack = 1'b0;

    typedef struct {
        bit          r;
        bit          f;
        bit          b;
        logic [31:0] ba;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pcif;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] m_addr();
        return m_drop ? m_drop_addr : m_pc;
    endfunction

    function automatic bit auto_ack();
        if (!m_out) return 1'b0;
        if (rand_ack) return ($urandom % 2) == 1;
        return m_wait >= lat;
    endfunction

    function automatic vec_t mk(input bit r, input bit f, input bit b, input logic [31:0] ba,
                                input bit er, input logic [31:0] ea, input bit ev,
                                input logic [31:0] ep);
        vec_t v;
        v.r = r; v.f = f; v.b = b; v.ba = ba;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pcif = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s/%s: got %h, expected %h", phase, name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s/%s: got %b, expected %b", phase, name, act, exp);
    endtask

    task automatic bound_chk(input string name, input int n, input int lim);
        ntotal++;
        if (n < lim) npass++;
        else $display("FAIL %s/%s: waited %0d cycles, required fewer than %0d", phase, name, n, lim);
    endtask

    task automatic model_update(input bit r, input bit f, input bit b, input logic [31:0] ba,
                                input bit a, input logic [31:0] rd);
        bit pop;
        bit got;
        bit pending;
        if (!r) begin
            mq.delete();
            m_pc   = RESET_PC;
            m_out  = 1'b0;
            m_drop = 1'b0;
            m_wait = 0;
            return;
        end
        pop     = (mq.size() > 0) && !f && !b;
        got     = m_out && a;
        pending = m_out && !a;
        if (b) begin
            mq.delete();
            if (pending && !m_drop) begin
                m_drop      = 1'b1;
                m_drop_addr = m_pc;
            end
            if (got) m_drop = 1'b0;
            m_pc = ba;
        end else begin
            if (pop) void'(mq.pop_front());
            if (got) begin
                if (m_drop) begin
                    m_drop = 1'b0;
                end else begin
                    mq.push_back(ent_t'{instr: rd, pcp4: m_pc + 32'd4});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        m_wait = pending ? m_wait + 1 : 0;
        m_out  = pending || (mq.size() < DEPTH);
    endtask

    task automatic check_model();
        logic [31:0] ei;
        logic [31:0] ep;
        bit          ev;
        ev = mq.size() > 0;
        ei = 32'h0;
        ep = 32'h0;
        if (ev) begin
            ei = mq[0].instr;
            ep = mq[0].pcp4;
        end
        chk1("model_req", imem_req, m_out);
        if (m_out) chk("model_addr", imem_addr, m_addr());
        chk1("model_valid", fetch_valid, ev);
        chk("model_instr", instruction_IF, ei);
        chk("model_pc_IF", pc_IF, ep);
    endtask

    task automatic tick(input bit r, input bit f, input bit b, input logic [31:0] ba, input bit a);
        rst          = r;
        freeze       = f;
        branch_taken = b;
        branch_addr  = ba;
        imem_ack     = a;
        imem_rdata   = memword(m_addr());
        @(posedge clk);
        model_update(r, f, b, ba, a, imem_rdata);
        @(negedge clk);
        check_model();
    endtask

    initial begin
        int n;
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;

        // Reset release and streaming I0..I3 with a same-cycle-ack memory.
        phase = "stream";
        lat = 0;
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 32'h0, 0, 0));
`ifdef FETCH_PREFETCH_EN
        tbl.push_back(mk(1, 0, 0, 0, 1, 32'h4,  1, 32'h4));
        tbl.push_back(mk(1, 0, 0, 0, 1, 32'h8,  1, 32'h8));
        tbl.push_back(mk(1, 0, 0, 0, 1, 32'hC,  1, 32'hC));
        tbl.push_back(mk(1, 0, 0, 0, 1, 32'h10, 1, 32'h10));
`else
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,     1, 32'h4));
        tbl.push_back(mk(1, 0, 0, 0, 1, 32'h4, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,     1, 32'h8));
        tbl.push_back(mk(1, 0, 0, 0, 1, 32'h8, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,     1, 32'hC));
        tbl.push_back(mk(1, 0, 0, 0, 1, 32'hC, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,     1, 32'h10));
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].r, tbl[i].f, tbl[i].b, tbl[i].ba, auto_ack());
            chk1("tbl_req", imem_req, tbl[i].e_req);
            if (tbl[i].e_req) chk("tbl_addr", imem_addr, tbl[i].e_addr);
            chk1("tbl_valid", fetch_valid, tbl[i].e_valid);
            chk("tbl_pc_IF", pc_IF, tbl[i].e_pcif);
            chk("tbl_instr", instruction_IF, tbl[i].e_valid ? memword(tbl[i].e_pcif - 32'd4) : 32'h0);
        end

        // Freeze for three cycles while I1 is at the head.
        phase = "freeze";
        tick(0, 0, 0, 0, 0);
        n = 0;
        do begin
            tick(1, 0, 0, 0, auto_ack());
            n++;
        end while (!(mq.size() > 0 && mq[0].pcp4 == 32'h8) && n < 20);
        bound_chk("reach_I1", n, 20);
        chk("head_pc_IF", pc_IF, 32'h8);
`ifdef FETCH_PREFETCH_EN
        chk1("pre_req", imem_req, 1'b1);
        chk("pre_addr", imem_addr, 32'h8);
`else
        chk1("pre_req", imem_req, 1'b0);
`endif
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, 0, 0, auto_ack());
            chk1("frz_req", imem_req, 1'b0);
            chk("frz_pc_IF", pc_IF, 32'h8);
            chk("frz_instr", instruction_IF, memword(32'h4));
        end
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 0, auto_ack());

        // Branch while a slow request is outstanding: its data must be discarded.
        phase = "drop";
        lat = 3;
        tick(0, 0, 0, 0, 0);
        n = 0;
        do begin
            tick(1, 0, 0, 0, auto_ack());
            n++;
        end while (!(m_out && !m_drop && m_pc == 32'h8 && m_wait == 0) && n < 60);
        bound_chk("reach_req8", n, 60);
        chk("req8_addr", imem_addr, 32'h8);
        tick(1, 0, 1, 32'h100, auto_ack());
        chk1("drop_req", imem_req, 1'b1);
        chk("drop_addr", imem_addr, 32'h8);
        chk1("drop_valid", fetch_valid, 1'b0);
        n = 0;
        do begin
            tick(1, 0, 0, 0, auto_ack());
            n++;
        end while (m_drop && n < 10);
        bound_chk("drop_end", n, 10);
        chk("redirect_addr", imem_addr, 32'h100);
        chk1("discard_valid", fetch_valid, 1'b0);
        n = 0;
        do begin
            tick(1, 0, 0, 0, auto_ack());
            n++;
        end while (mq.size() == 0 && n < 10);
        bound_chk("first_valid", n, 10);
        chk("target_pc_IF", pc_IF, 32'h104);
        chk("target_instr", instruction_IF, memword(32'h100));

        // Branch and freeze together with a full queue.
        phase = "br_frz";
        lat = 0;
        tick(0, 0, 0, 0, 0);
        n = 0;
        do begin
            tick(1, 1, 0, 0, auto_ack());
            n++;
        end while (mq.size() < DEPTH && n < 20);
        bound_chk("fill", n, 20);
        chk1("full_valid", fetch_valid, 1'b1);
        tick(1, 1, 1, 32'h200, auto_ack());
        chk1("flush_valid", fetch_valid, 1'b0);
        chk("flush_pc_IF", pc_IF, 32'h0);
        chk("flush_instr", instruction_IF, 32'h0);
        chk1("flush_req", imem_req, 1'b1);
        chk("flush_addr", imem_addr, 32'h200);

        // Reset in the middle of a request; the late acks must be ignored.
        phase = "rst_mid";
        lat = 1;
        tick(0, 0, 0, 0, 0);
        n = 0;
        do begin
            tick(1, 0, 0, 0, auto_ack());
            n++;
        end while (!(m_out && !m_drop && m_pc == 32'h20 && m_wait == 0) && n < 100);
        bound_chk("reach_req20", n, 100);
        chk("req20_addr", imem_addr, 32'h20);
        tick(0, 0, 0, 0, 0);
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_valid", fetch_valid, 1'b0);
        chk("rst_instr", instruction_IF, 32'h0);
        chk("rst_pc_IF", pc_IF, 32'h0);
        tick(0, 0, 0, 0, 1);
        chk1("rst_ack_valid", fetch_valid, 1'b0);
        tick(1, 0, 0, 0, 1);
        chk1("late_ack_valid", fetch_valid, 1'b0);
        chk1("restart_req", imem_req, 1'b1);
        chk("restart_addr", imem_addr, RESET_PC);
        n = 0;
        do begin
            tick(1, 0, 0, 0, auto_ack());
            n++;
        end while (mq.size() == 0 && n < 10);
        bound_chk("restart_valid", n, 10);
        chk("restart_pc_IF", pc_IF, RESET_PC + 32'd4);

        // PC wrap at the top of the address space.
        phase = "wrap";
        lat = 0;
        tick(0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, auto_ack());
        tick(1, 0, 1, 32'hFFFF_FFFC, auto_ack());
        chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        chk1("wrap_pre_valid", fetch_valid, 1'b0);
        tick(1, 0, 0, 0, auto_ack());
        chk1("wrap_valid", fetch_valid, 1'b1);
        chk("wrap_pc_IF", pc_IF, 32'h0);
        chk("wrap_instr", instruction_IF, memword(32'hFFFF_FFFC));
        n = 0;
        while (!m_out && n < 10) begin
            tick(1, 0, 0, 0, auto_ack());
            n++;
        end
        bound_chk("wrap_next_req", n, 10);
        chk("wrap_next_addr", imem_addr, 32'h0);

        // Random traffic against the model.
        phase = "random";
        rand_ack = 1'b1;
        tick(0, 0, 0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            bit          r;
            bit          f;
            bit          b;
            logic [31:0] ba;
            r  = ($urandom % 60) != 0;
            f  = ($urandom % 10) < 3;
            b  = ($urandom % 16) == 0;
            ba = $urandom & 32'hFFFF_FFFC;
            tick(r, f, b, ba, auto_ack());
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
